// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time and
// feeds a registered IF/ID stage with decode stall and execute redirect/flush.
module instr_fetch_stage #(
    parameter int unsigned          WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 IMemReq,
    output logic [WORD_SIZE-1:0] IMemAddr,
    input  logic                 IMemReady,
    input  logic                 IMemValid,
    input  logic [WORD_SIZE-1:0] IMemRData,
    input  logic                 Stall,
    input  logic                 Redirect,
    input  logic [WORD_SIZE-1:0] RedirectPC,
    output logic                 ValidD,
    output logic [WORD_SIZE-1:0] InstrD,
    output logic [WORD_SIZE-1:0] PCD,
    output logic [WORD_SIZE-1:0] PCPlus4D
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_DROP
    } state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] hold;
    logic [WORD_SIZE-1:0] pc_plus4;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 accept;
    logic                 load_ok;
    logic                 redirect_lsb_unused;

    assign pc_plus4            = pc + WORD_SIZE'(4);
    assign redirect_pc         = {RedirectPC[WORD_SIZE-1:2], 2'b00};
    assign redirect_lsb_unused = ^RedirectPC[1:0];
    assign load_ok             = !ValidD || !Stall;
    assign accept              = IMemReq && IMemReady;
    assign IMemAddr            = pc;

    // NOTE: the request is a decode of the state gated by reset, so it drops the
    // instant reset asserts rather than one edge later as a separate flop would.
    assign IMemReq = reset && (state == ST_REQ);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_REQ;
            pc       <= RESET_VECTOR;
            hold     <= '0;
            ValidD   <= 1'b0;
            InstrD   <= '0;
            PCD      <= '0;
            PCPlus4D <= '0;
        end else begin
            if (ValidD && !Stall) begin
                ValidD <= 1'b0;
            end

            case (state)
                ST_REQ: begin
                    if (Redirect) begin
                        pc <= redirect_pc;
                    end
                    if (accept) begin
                        state <= Redirect ? ST_DROP : ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (Redirect) begin
                        pc    <= redirect_pc;
                        state <= IMemValid ? ST_REQ : ST_DROP;
                    end else if (IMemValid) begin
                        if (load_ok) begin
                            InstrD   <= IMemRData;
                            PCD      <= pc;
                            PCPlus4D <= pc_plus4;
                            ValidD   <= 1'b1;
                            pc       <= pc_plus4;
                            state    <= ST_REQ;
                        end else begin
                            hold  <= IMemRData;
                            state <= ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (Redirect) begin
                        pc    <= redirect_pc;
                        state <= ST_REQ;
                    end else if (load_ok) begin
                        InstrD   <= hold;
                        PCD      <= pc;
                        PCPlus4D <= pc_plus4;
                        ValidD   <= 1'b1;
                        pc       <= pc_plus4;
                        state    <= ST_REQ;
                    end
                end

                ST_DROP: begin
                    // The stale response still owed by memory must be swallowed here.
                    if (Redirect) begin
                        pc <= redirect_pc;
                    end
                    if (IMemValid) begin
                        state <= ST_REQ;
                    end
                end

                default: state <= ST_REQ;
            endcase

            // NOTE: with non-blocking assignments the last one in the block wins,
            // so placing the flush here lets it override any load made above.
            if (Redirect) begin
                ValidD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed memory responses with a
// scoreboard of expected IF/ID deliveries popped whenever decode consumes.
module tb_instr_fetch_stage;

    localparam int unsigned W  = 32;
    localparam logic [W-1:0] RV = 32'h0000_0100;

    logic         clk;
    logic         reset;
    logic         IMemReq;
    logic [W-1:0] IMemAddr;
    logic         IMemReady;
    logic         IMemValid;
    logic [W-1:0] IMemRData;
    logic         Stall;
    logic         Redirect;
    logic [W-1:0] RedirectPC;
    logic         ValidD;
    logic [W-1:0] InstrD;
    logic [W-1:0] PCD;
    logic [W-1:0] PCPlus4D;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    instr_fetch_stage #(
        .WORD_SIZE   (W),
        .RESET_VECTOR(RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .IMemReq   (IMemReq),
        .IMemAddr  (IMemAddr),
        .IMemReady (IMemReady),
        .IMemValid (IMemValid),
        .IMemRData (IMemRData),
        .Stall     (Stall),
        .Redirect  (Redirect),
        .RedirectPC(RedirectPC),
        .ValidD    (ValidD),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in REQ just after an edge; one-cycle accept, one-cycle response.
    task automatic do_fetch(input logic [W-1:0] addr, input logic [W-1:0] data);
        IMemReady = 1'b1;
        @(negedge clk);
        check("fetch_req", 32'(IMemReq), 32'd1);
        check("fetch_addr", IMemAddr, addr);
        tick();
        IMemReady = 1'b0;
        IMemValid = 1'b1;
        IMemRData = data;
        sb.push_back('{pc: addr, instr: data});
        tick();
        IMemValid = 1'b0;
    endtask

    // Decode consumes whenever ValidD is high and Stall is low.
    always @(negedge clk) begin
        if (reset && ValidD && !Stall) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_pcd", PCD, e.pc);
                check("sb_instr", InstrD, e.instr);
                check("sb_pcplus4", PCPlus4D, e.pc + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        IMemReady  = 1'b0;
        IMemValid  = 1'b0;
        IMemRData  = '0;
        Stall      = 1'b0;
        Redirect   = 1'b0;
        RedirectPC = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", 32'(IMemReq), 32'd0);
        check("rst_valid", 32'(ValidD), 32'd0);
        check("rst_instr", InstrD, 32'd0);
        check("rst_pcd", PCD, 32'd0);
        check("rst_pcplus4", PCPlus4D, 32'd0);
        check("rst_addr", IMemAddr, RV);
        @(posedge clk);
        #1 reset = 1'b1;

        // First fetch at the reset vector, minimum latency
        do_fetch(32'h100, 32'h0050_0093);
        @(negedge clk);
        check("t1_valid", 32'(ValidD), 32'd1);
        check("t1_instr", InstrD, 32'h0050_0093);
        check("t1_pcd", PCD, 32'h100);
        check("t1_pcplus4", PCPlus4D, 32'h104);
        check("t1_next_req", 32'(IMemReq), 32'd1);
        check("t1_next_addr", IMemAddr, 32'h104);

        // Memory not ready: request held with a stable address
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("t2_req", 32'(IMemReq), 32'd1);
            check("t2_addr", IMemAddr, 32'h104);
            check("t2_novalid", 32'(ValidD), 32'd0);
        end
        tick();
        do_fetch(32'h104, 32'h00A0_0113);

        // Response lands while decode stalls: parked in the hold register
        Stall     = 1'b1;
        IMemReady = 1'b1;
        @(negedge clk);
        check("t3_addr", IMemAddr, 32'h108);
        tick();
        IMemReady = 1'b0;
        IMemValid = 1'b1;
        IMemRData = 32'hDEAD_BEEF;
        sb.push_back('{pc: 32'h108, instr: 32'hDEAD_BEEF});
        @(negedge clk);
        check("t3_wait_req", 32'(IMemReq), 32'd0);
        tick();
        IMemValid = 1'b0;
        @(negedge clk);
        check("t3_hold_instr", InstrD, 32'h00A0_0113);
        check("t3_hold_pcd", PCD, 32'h104);
        check("t3_hold_req", 32'(IMemReq), 32'd0);
        check("t3_hold_addr", IMemAddr, 32'h108);
        tick();
        Stall = 1'b0;
        @(negedge clk);
        check("t3_hold2_instr", InstrD, 32'h00A0_0113);
        tick();
        IMemReady = 1'b1;
        @(negedge clk);
        check("t3_instr", InstrD, 32'hDEAD_BEEF);
        check("t3_pcd", PCD, 32'h108);
        check("t3_next_addr", IMemAddr, 32'h10C);
        check("t3_next_req", 32'(IMemReq), 32'd1);

        // Redirect while waiting: stale response dropped
        tick();
        IMemReady  = 1'b0;
        Redirect   = 1'b1;
        RedirectPC = 32'h203;
        @(negedge clk);
        check("t4_wait_req", 32'(IMemReq), 32'd0);
        tick();
        Redirect = 1'b0;
        @(negedge clk);
        check("t4_flush_valid", 32'(ValidD), 32'd0);
        check("t4_drop_req", 32'(IMemReq), 32'd0);
        check("t4_drop_addr", IMemAddr, 32'h200);
        tick();
        IMemValid = 1'b1;
        IMemRData = 32'hBAD0_BAD0;
        @(negedge clk);
        check("t4_drop2_req", 32'(IMemReq), 32'd0);
        tick();
        IMemValid = 1'b0;
        do_fetch(32'h200, 32'h0000_0013);

        // Redirect on accept, then again while dropping
        IMemReady  = 1'b1;
        Redirect   = 1'b1;
        RedirectPC = 32'h300;
        @(negedge clk);
        check("t5_acc_addr", IMemAddr, 32'h204);
        tick();
        IMemReady  = 1'b0;
        RedirectPC = 32'h400;
        @(negedge clk);
        check("t5_drop_req", 32'(IMemReq), 32'd0);
        check("t5_drop_addr", IMemAddr, 32'h300);
        check("t5_drop_valid", 32'(ValidD), 32'd0);
        tick();
        Redirect  = 1'b0;
        IMemValid = 1'b1;
        IMemRData = 32'hBAAD_F00D;
        @(negedge clk);
        check("t5_redrop_req", 32'(IMemReq), 32'd0);
        check("t5_redrop_addr", IMemAddr, 32'h400);
        tick();
        IMemValid = 1'b0;
        do_fetch(32'h400, 32'h0010_0073);

        // PC wrap; low redirect bits are ignored
        Redirect   = 1'b1;
        RedirectPC = 32'hFFFF_FFFF;
        @(negedge clk);
        check("t6_pre_addr", IMemAddr, 32'h404);
        tick();
        Redirect = 1'b0;
        do_fetch(32'hFFFF_FFFC, 32'h0000_0013);
        Stall     = 1'b1;
        IMemReady = 1'b1;
        @(negedge clk);
        check("t6_valid", 32'(ValidD), 32'd1);
        check("t6_pcd", PCD, 32'hFFFF_FFFC);
        check("t6_pcplus4", PCPlus4D, 32'h0000_0000);
        check("t6_next_addr", IMemAddr, 32'h0000_0000);
        tick();
        IMemReady = 1'b0;

        // Asynchronous reset in the middle of a WAIT cycle
        #2 reset = 1'b0;
        #1;
        check("t7_req", 32'(IMemReq), 32'd0);
        check("t7_valid", 32'(ValidD), 32'd0);
        check("t7_addr", IMemAddr, RV);
        check("t7_instr", InstrD, 32'd0);
        // The stalled wrap instruction was never consumed and reset discards it.
        check("t7_sb_pending", 32'(sb.size()), 32'd1);
        sb.delete();
        Stall = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        do_fetch(32'h100, 32'h0050_0093);
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
